alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset: clk (rising-edge) and rst_n.
REQ-002 The block SHALL have the following ports:
  - clk  in  1  clock
  - rst_n  in  1  async active-low reset
  - in_valid  in  1  upstream op valid
  - in_ready  out  1  block can accept op
  - in_op  in  4  [3:2] class (00 add, 01 bool, 10 shift, 11 illegal), [1:0] sub-op
  - in_a  in  32  operand A
  - in_b  in  32  operand B
  - stall  in  1  downstream hold; issue register frozen while high
  - en  out  3  one-hot unit select to result mux: bit0 add, bit1 bool, bit2 shift
  - fu_op  out  2  sub-op to selected unit
  - fu_a  out  32  operand A to units
  - fu_b  out  32  operand B to units
  - res_valid  out  1  registered mux output holds a fired op's result this cycle
  - res_err  out  1  fired op was illegal class
  - issue_cnt  out  16  count of legal ops fired, saturating

Function
REQ-003 Input handshake: an op SHALL transfer when in_valid && in_ready at a rising clk edge.
REQ-004 Storage: one skid entry plus one issue register; ops SHALL leave in arrival order.
REQ-005 Advance condition: adv = !iss_valid || !stall.
REQ-006 Issue register source on adv: the skid entry if the skid is valid, else the accepted input, else the register SHALL become empty.
REQ-007 An accepted input SHALL go to the skid when !adv, or when adv and the skid is already valid.
REQ-008 The skid SHALL become empty when it drains on adv and no input lands in it.
REQ-009 in_ready SHALL be the registered value !skid_valid; it SHALL NOT depend combinationally on stall or in_valid.
REQ-010 Skid full and stall high: in_ready=0 and no op SHALL be lost or overwritten.
REQ-011 en SHALL be one-hot of the issue-register class when iss_valid and the class is legal, else 3'b000.
REQ-012 en SHALL never have more than one bit set.
REQ-013 fu_op, fu_a and fu_b SHALL be issue-register contents and SHALL be 0 when !iss_valid.
REQ-014 Fire: fire = iss_valid && !stall.
REQ-015 res_valid SHALL equal fire delayed by exactly one clk, matching the one-cycle registered result mux.
REQ-016 res_err SHALL equal (fire && illegal class) delayed by one clk.
REQ-017 res_valid SHALL be 1 for an illegal op (with res_err=1); the mux output is then 0.
REQ-018 While stall=1, en, fu_* SHALL hold stable and res_valid SHALL be 0 the following cycle.
REQ-019 issue_cnt SHALL increment on each fire of a legal op, hold at 16'hFFFF, and not wrap.
REQ-020 Latency: an accepted op into an empty block with stall=0 SHALL drive en the next cycle and res_valid the cycle after (2 cycles from accept).
REQ-021 Throughput: with stall=0 the block SHALL sustain one op per cycle with in_ready held 1.
REQ-022 Simultaneous accept and fire SHALL be legal and in-order.

Reset
REQ-023 On rst_n low, asynchronously, all state SHALL clear: iss_valid=0, skid_valid=0, in_ready=1, en=0, fu_op=0, fu_a=0, fu_b=0, res_valid=0, res_err=0, issue_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard all held ops; no res_valid SHALL follow deassertion.
REQ-025 The first accept after deassertion SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-026 Single add: op=4'b0001, a=5, b=7, stall=0 -> en=001, fu_op=01 next cycle; res_valid=1, res_err=0 the cycle after; issue_cnt=1.
REQ-027 Back-to-back add, bool, shift, stall=0 -> en sequence 001, 010, 100 on consecutive cycles; three res_valid pulses; in_ready stays 1.
REQ-028 Stall for 3 cycles with a third op offered -> skid fills, in_ready=0, en held stable, no res_valid; on release the ops fire in original order.
REQ-029 Illegal op=4'b1100 -> en=000, res_valid=1, res_err=1; issue_cnt unchanged.
REQ-030 issue_cnt preloaded near 16'hFFFE by 3 legal fires -> value stops at 16'hFFFF.
REQ-031 Reset with both skid and issue full -> all outputs 0, in_ready=1, no res_valid after release.

Source files
------------

// File: rtl/alu_dispatch.sv
// Issue stage for a small ALU cluster: a one-entry skid plus an issue register feed
// one-hot unit enables and operands, and a registered valid/error pair tracks fired ops.
module alu_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        stall,
  output logic [2:0]  en,
  output logic [1:0]  fu_op,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic        res_valid,
  output logic        res_err,
  output logic [15:0] issue_cnt
);

  localparam int DATA_W = 32;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              skid_valid_q, skid_valid_d;
  logic [3:0]        skid_op_q, skid_op_d;
  logic [DATA_W-1:0] skid_a_q, skid_a_d;
  logic [DATA_W-1:0] skid_b_q, skid_b_d;
  logic              iss_valid_q, iss_valid_d;
  logic [3:0]        iss_op_q, iss_op_d;
  logic [DATA_W-1:0] iss_a_q, iss_a_d;
  logic [DATA_W-1:0] iss_b_q, iss_b_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              res_err_q, res_err_d;
  logic [15:0]       issue_cnt_q, issue_cnt_d;

  logic accept, adv, fire, iss_illegal;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    iss_valid_d  = iss_valid_q;
    iss_op_d     = iss_op_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;

    accept      = in_valid && in_ready_q;
    adv         = !iss_valid_q || !stall;
    fire        = iss_valid_q && !stall;
    iss_illegal = (iss_op_q[3:2] == 2'b11);

    if (adv) begin
      if (skid_valid_q) begin
        // Skid holds the older op, so it always issues ahead of any new arrival.
        iss_valid_d = 1'b1;
        iss_op_d    = skid_op_q;
        iss_a_d     = skid_a_q;
        iss_b_d     = skid_b_q;
        if (accept) begin
          skid_op_d = in_op;
          skid_a_d  = in_a;
          skid_b_d  = in_b;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        iss_valid_d = 1'b1;
        iss_op_d    = in_op;
        iss_a_d     = in_a;
        iss_b_d     = in_b;
      end else begin
        iss_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_op_d    = in_op;
      skid_a_d     = in_a;
      skid_b_d     = in_b;
    end

    in_ready_d  = !skid_valid_d;
    res_valid_d = fire;
    res_err_d   = fire && iss_illegal;
    issue_cnt_d = (fire && !iss_illegal) ? sat_inc(issue_cnt_q) : issue_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      iss_valid_q  <= 1'b0;
      iss_op_q     <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      in_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      res_err_q    <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      iss_valid_q  <= iss_valid_d;
      iss_op_q     <= iss_op_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      in_ready_q   <= in_ready_d;
      res_valid_q  <= res_valid_d;
      res_err_q    <= res_err_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  // Operands are masked while the issue register is empty so the units see quiet inputs.
  always_comb begin
    en    = 3'b000;
    fu_op = 2'b00;
    fu_a  = '0;
    fu_b  = '0;
    if (iss_valid_q) begin
      fu_op = iss_op_q[1:0];
      fu_a  = iss_a_q;
      fu_b  = iss_b_q;
      case (iss_op_q[3:2])
        2'b00:   en = 3'b001;
        2'b01:   en = 3'b010;
        2'b10:   en = 3'b100;
        default: en = 3'b000;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: a table of single-op vectors plus hand-written
// sequences for back-to-back issue, stall/skid, reset flush and counter saturation.
module tb_alu_dispatch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        stall;
  logic [2:0]  en;
  logic [1:0]  fu_op;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic        res_valid;
  logic        res_err;
  logic [15:0] issue_cnt;

  int tests;
  int fails;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .stall(stall),
    .en(en), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .res_valid(res_valid), .res_err(res_err), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  exp_en;
    logic [1:0]  exp_fu_op;
    logic        exp_err;
    logic [15:0] exp_inc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  vec_t        vecs[6];
  logic [15:0] exp_cnt;
  logic        rdy_ok;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{4'b0001, 32'd5,          32'd7,          3'b001, 2'b01, 1'b0, 16'd1};
    vecs[1] = '{4'b0110, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'b010, 2'b10, 1'b0, 16'd1};
    vecs[2] = '{4'b1011, 32'h8000_0001,  32'd4,          3'b100, 2'b11, 1'b0, 16'd1};
    vecs[3] = '{4'b1100, 32'hDEAD_BEEF,  32'h1234_5678,  3'b000, 2'b00, 1'b1, 16'd0};
    vecs[4] = '{4'b0000, 32'hFFFF_FFFF,  32'd1,          3'b001, 2'b00, 1'b0, 16'd1};
    vecs[5] = '{4'b1111, 32'd9,          32'd3,          3'b000, 2'b11, 1'b1, 16'd0};

    stall = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_en", {29'b0, en}, 32'd0);
    chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset_cnt", {16'b0, issue_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    exp_cnt = 16'd0;

    // Table: each op alone through an empty block.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      chk("vec_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk("vec_en", {29'b0, en}, {29'b0, vecs[i].exp_en});
      chk("vec_fu_op", {30'b0, fu_op}, {30'b0, vecs[i].exp_fu_op});
      chk("vec_fu_a", fu_a, vecs[i].a);
      chk("vec_fu_b", fu_b, vecs[i].b);
      chk("vec_res_valid_early", {31'b0, res_valid}, 32'd0);
      step();
      exp_cnt = exp_cnt + vecs[i].exp_inc;
      chk("vec_res_valid", {31'b0, res_valid}, 32'd1);
      chk("vec_res_err", {31'b0, res_err}, {31'b0, vecs[i].exp_err});
      chk("vec_cnt", {16'b0, issue_cnt}, {16'b0, exp_cnt});
      chk("vec_en_after", {29'b0, en}, 32'd0);
      chk("vec_fu_a_after", fu_a, 32'd0);
      step();
      chk("vec_res_valid_clear", {31'b0, res_valid}, 32'd0);
    end

    // Back-to-back add, bool, shift with stall low.
    drive(1'b1, 4'b0001, 32'd1, 32'd2);
    step();
    chk("b2b_en0", {29'b0, en}, 32'b001);
    chk("b2b_rdy0", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 4'b0100, 32'd3, 32'd4);
    step();
    chk("b2b_en1", {29'b0, en}, 32'b010);
    chk("b2b_rv1", {31'b0, res_valid}, 32'd1);
    chk("b2b_rdy1", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 4'b1000, 32'd5, 32'd6);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2b_en2", {29'b0, en}, 32'b100);
    chk("b2b_fu_a2", fu_a, 32'd5);
    chk("b2b_rv2", {31'b0, res_valid}, 32'd1);
    chk("b2b_rdy2", {31'b0, in_ready}, 32'd1);
    step();
    chk("b2b_rv3", {31'b0, res_valid}, 32'd1);
    chk("b2b_en_idle", {29'b0, en}, 32'd0);
    step();
    chk("b2b_rv_end", {31'b0, res_valid}, 32'd0);
    exp_cnt = exp_cnt + 16'd3;
    chk("b2b_cnt", {16'b0, issue_cnt}, {16'b0, exp_cnt});

    // Stall three cycles: A held in issue, B in skid, C waits upstream.
    drive(1'b1, 4'b0001, 32'hA, 32'hA0);
    step();
    stall = 1'b1;
    drive(1'b1, 4'b0101, 32'hB, 32'hB0);
    step();
    chk("stall_rdy", {31'b0, in_ready}, 32'd0);
    chk("stall_en", {29'b0, en}, 32'b001);
    chk("stall_fu_a", fu_a, 32'hA);
    drive(1'b1, 4'b1010, 32'hC, 32'hC0);
    step();
    chk("stall_rv", {31'b0, res_valid}, 32'd0);
    chk("stall_en_hold", {29'b0, en}, 32'b001);
    chk("stall_rdy_hold", {31'b0, in_ready}, 32'd0);
    step();
    chk("stall_rv2", {31'b0, res_valid}, 32'd0);
    chk("stall_fu_b_hold", fu_b, 32'hA0);
    stall = 1'b0;
    step();
    chk("rel_rv_a", {31'b0, res_valid}, 32'd1);
    chk("rel_en_b", {29'b0, en}, 32'b010);
    chk("rel_fu_a_b", fu_a, 32'hB);
    chk("rel_rdy", {31'b0, in_ready}, 32'd1);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rel_rv_b", {31'b0, res_valid}, 32'd1);
    chk("rel_en_c", {29'b0, en}, 32'b100);
    chk("rel_fu_a_c", fu_a, 32'hC);
    step();
    chk("rel_rv_c", {31'b0, res_valid}, 32'd1);
    step();
    exp_cnt = exp_cnt + 16'd3;
    chk("rel_cnt", {16'b0, issue_cnt}, {16'b0, exp_cnt});

    // Reset with skid and issue register both full.
    drive(1'b1, 4'b0001, 32'h11, 32'h22);
    step();
    stall = 1'b1;
    drive(1'b1, 4'b0100, 32'h33, 32'h44);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_pre_rdy", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rdy", {31'b0, in_ready}, 32'd1);
    chk("rst_async_en", {29'b0, en}, 32'd0);
    chk("rst_async_fu", fu_a | fu_b | {30'b0, fu_op}, 32'd0);
    chk("rst_async_rv", {31'b0, res_valid | res_err}, 32'd0);
    chk("rst_async_cnt", {16'b0, issue_cnt}, 32'd0);
    #3;
    stall = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_after_rv0", {31'b0, res_valid}, 32'd0);
    chk("rst_after_en0", {29'b0, en}, 32'd0);
    step();
    chk("rst_after_rv1", {31'b0, res_valid}, 32'd0);
    chk("rst_after_cnt", {16'b0, issue_cnt}, 32'd0);

    // Saturation: 65534 legal fires reach FFFE, three more stop at FFFF.
    do_reset();
    rdy_ok = 1'b1;
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    for (int i = 0; i < 65534; i++) begin
      step();
      if (!in_ready) rdy_ok = 1'b0;
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    chk("stream_rdy", {31'b0, rdy_ok}, 32'd1);
    chk("sat_fffe", {16'b0, issue_cnt}, 32'h0000_FFFE);
    drive(1'b1, 4'b0001, 32'd2, 32'd2);
    step();
    step();
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("sat_last_rv", {31'b0, res_valid}, 32'd1);
    step();
    chk("sat_ffff", {16'b0, issue_cnt}, 32'h0000_FFFF);
    drive(1'b1, 4'b1100, 32'd0, 32'd0);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("sat_illegal_err", {31'b0, res_err}, 32'd1);
    chk("sat_hold", {16'b0, issue_cnt}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
